buf_id_pool: RTL and testbench

//  Parametrised free-list manager for data_cache buffer blocks. Issues a free block
//  ID and base address to the ingress writer; takes back released IDs from egress.

---
 rtl/buf_id_pool_pkg.sv | 14 +
 rtl/buf_id_pool_id_free_fifo.sv | 50 +++++
 rtl/buf_id_pool.sv | 128 ++++++++++++
 tb/tb_buf_id_pool.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_id_pool_pkg.sv
// Shared defaults and FSM encoding for the buffer-ID pool.
package buf_id_pool_pkg;

  localparam int DEF_ID_W      = 4;
  localparam int DEF_BLK_SHIFT = 7;
  localparam int DEF_FAN_W     = 3;
  localparam int DEF_LOW_WM    = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pool_state_t;

endpackage

// File: rtl/buf_id_pool_id_free_fifo.sv
// Show-ahead sync FIFO holding free IDs; rd_dat is the head while !empty.
// Simultaneous rd/wr keeps data_count; caller must not read when empty or write when full.
module id_free_fifo #(
  parameter int DEPTH_W = 4,
  parameter int DAT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [DAT_W-1:0]   wr_dat,
  input  logic               rd_en,
  output logic [DAT_W-1:0]   rd_dat,
  output logic [DEPTH_W:0]   data_count,
  output logic               empty,
  output logic               full
);

  localparam int DEPTH = 2**DEPTH_W;

  logic [DAT_W-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic               rd_fire;

  assign empty   = (data_count == '0);
  assign full    = data_count[DEPTH_W];
  assign rd_dat  = mem[rd_ptr];
  assign rd_fire = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (rd_fire) rd_ptr <= rd_ptr + DEPTH_W'(1);
      case ({wr_en, rd_fire})
        2'b10:   data_count <= data_count + (DEPTH_W+1)'(1);
        2'b01:   data_count <= data_count - (DEPTH_W+1)'(1);
        default: data_count <= data_count;
      endcase
    end
  end

endmodule

// File: rtl/buf_id_pool.sv
// Free-list manager for cache buffer blocks with per-ID multicast reference counts.
// Alloc is valid/ready from the FIFO head; a final release reaches the list one cycle later.
module buf_id_pool
  import buf_id_pool_pkg::*;
#(
  parameter int ID_W      = DEF_ID_W,
  parameter int BLK_SHIFT = DEF_BLK_SHIFT,
  parameter int FAN_W     = DEF_FAN_W,
  parameter int LOW_WM    = DEF_LOW_WM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   alloc_valid,
  input  logic                   alloc_ready,
  output logic [ID_W-1:0]        alloc_id,
  output logic [ID_W+BLK_SHIFT-1:0] alloc_addr,
  input  logic [FAN_W-1:0]       alloc_fanout,
  input  logic                   release_valid,
  output logic                   release_ready,
  input  logic [ID_W-1:0]        release_id,
  output logic [ID_W:0]          free_cnt,
  output logic                   init_done,
  output logic                   low_wm,
  output logic                   err_pulse
);

  localparam int NUM_IDS = 2**ID_W;
  localparam logic [ID_W:0] LOW_WM_V = (ID_W+1)'(LOW_WM);

  pool_state_t        state;
  logic [ID_W-1:0]    init_cnt;
  logic               alloc_en;
  logic [FAN_W-1:0]   refcnt [NUM_IDS];
  logic               push_vld;
  logic [ID_W-1:0]    push_id;

  logic               fifo_wr;
  logic [ID_W-1:0]    fifo_wdat;
  logic [ID_W-1:0]    fifo_rdat;
  logic [ID_W:0]      fifo_cnt;
  logic               fifo_empty;
  logic               fifo_full;

  logic               pop;
  logic               rel_acc;
  logic [FAN_W-1:0]   rel_cnt;
  logic [FAN_W-1:0]   fan_eff;

  assign alloc_valid   = alloc_en && !fifo_empty;
  assign pop           = alloc_valid && alloc_ready;
  assign alloc_id      = alloc_valid ? fifo_rdat : '0;
  assign alloc_addr    = {alloc_id, {BLK_SHIFT{1'b0}}};
  assign release_ready = init_done;
  assign rel_acc       = release_valid && release_ready;
  assign rel_cnt       = refcnt[release_id];
  assign fan_eff       = (alloc_fanout == '0) ? FAN_W'(1) : alloc_fanout;
  assign free_cnt      = fifo_cnt;
  assign low_wm        = init_done && (fifo_cnt <= LOW_WM_V);

  // INIT and release pushes never overlap: release_ready stays low until RUN.
  assign fifo_wr   = (state == ST_INIT) || push_vld;
  assign fifo_wdat = (state == ST_INIT) ? init_cnt : push_id;

  id_free_fifo #(
    .DEPTH_W (ID_W),
    .DAT_W   (ID_W)
  ) u_free_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (fifo_wr),
    .wr_dat     (fifo_wdat),
    .rd_en      (pop),
    .rd_dat     (fifo_rdat),
    .data_count (fifo_cnt),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      alloc_en  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + ID_W'(1);
          if (&init_cnt) state <= ST_RUN;
        end
        ST_RUN: begin
          init_done <= 1'b1;
          alloc_en  <= init_done;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // A popped ID always has refcnt 0, so a same-cycle release of it is the error case
  // and never writes; the pop write below therefore cannot collide with a release write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IDS; i++) refcnt[i] <= '0;
      push_vld  <= 1'b0;
      push_id   <= '0;
      err_pulse <= 1'b0;
    end else begin
      push_vld  <= 1'b0;
      err_pulse <= 1'b0;
      if (rel_acc) begin
        if (rel_cnt == '0) begin
          err_pulse <= 1'b1;
        end else if (rel_cnt == FAN_W'(1)) begin
          refcnt[release_id] <= '0;
          push_vld           <= 1'b1;
          push_id            <= release_id;
        end else begin
          refcnt[release_id] <= rel_cnt - FAN_W'(1);
        end
      end
      if (pop) refcnt[fifo_rdat] <= fan_eff;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr && fifo_full));

endmodule

// File: tb/tb_buf_id_pool.sv
module tb_buf_id_pool;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_id;
  logic [10:0] alloc_addr;
  logic [2:0]  alloc_fanout;
  logic        release_valid;
  logic        release_ready;
  logic [3:0]  release_id;
  logic [4:0]  free_cnt;
  logic        init_done;
  logic        low_wm;
  logic        err_pulse;

  int n_chk = 0;
  int n_err = 0;

  buf_id_pool dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_id      (alloc_id),
    .alloc_addr    (alloc_addr),
    .alloc_fanout  (alloc_fanout),
    .release_valid (release_valid),
    .release_ready (release_ready),
    .release_id    (release_id),
    .free_cnt      (free_cnt),
    .init_done     (init_done),
    .low_wm        (low_wm),
    .err_pulse     (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a queue of free IDs, a reference count per ID, and edges counted since reset.
  // Edges 0..15 load IDs 0..15; release is accepted from edge 17; alloc shows from cycle 17.
  int m_q[$];
  int m_rc[16];
  int m_n    = 0;
  int m_pend = -1;
  bit m_err  = 1'b0;
  bit mv, mrr;
  int mhead, mr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      foreach (m_rc[i]) m_rc[i] = 0;
      m_n    = 0;
      m_pend = -1;
      m_err  = 1'b0;
    end else begin
      mv    = (m_n >= 18) && (m_q.size() > 0);
      mrr   = (m_n >= 17);
      mhead = mv ? m_q[0] : 0;
      if (mv && alloc_ready) void'(m_q.pop_front());
      if (m_pend >= 0) m_q.push_back(m_pend);
      if (m_n < 16) m_q.push_back(m_n);
      m_pend = -1;
      m_err  = 1'b0;
      if (release_valid && mrr) begin
        mr = m_rc[int'(release_id)];
        if (mr == 0) m_err = 1'b1;
        else if (mr == 1) begin
          m_rc[int'(release_id)] = 0;
          m_pend = int'(release_id);
        end else m_rc[int'(release_id)] = mr - 1;
      end
      if (mv && alloc_ready) m_rc[mhead] = (alloc_fanout == 3'd0) ? 1 : int'(alloc_fanout);
      if (m_n < 1000) m_n++;
    end
  end

  bit e_v, e_done;
  int e_id, e_cnt;

  always @(negedge clk) begin
    e_v    = (m_n >= 18) && (m_q.size() > 0);
    e_done = (m_n >= 17);
    e_id   = e_v ? m_q[0] : 0;
    e_cnt  = m_q.size();
    chk("m_alloc_valid", alloc_valid, e_v);
    chk("m_alloc_id", alloc_id, e_id);
    chk("m_alloc_addr", alloc_addr, e_id * 128);
    chk("m_free_cnt", free_cnt, e_cnt);
    chk("m_init_done", init_done, e_done);
    chk("m_release_ready", release_ready, e_done);
    chk("m_low_wm", low_wm, e_done && (e_cnt <= 2));
    chk("m_err_pulse", err_pulse, m_err);
  end

  initial begin
    alloc_ready   = 1'b0;
    alloc_fanout  = 3'd0;
    release_valid = 1'b0;
    release_id    = 4'd0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Init and first head
    repeat (16) tick();
    @(negedge clk);
    chk("init_c15", init_done, 0);
    tick(); @(negedge clk);
    chk("init_c16", init_done, 1);
    chk("free_c16", free_cnt, 16);
    chk("valid_c16", alloc_valid, 0);
    tick(); @(negedge clk);
    chk("valid_c17", alloc_valid, 1);
    chk("id_c17", alloc_id, 0);
    chk("addr_c17", alloc_addr, 0);

    // Drain all IDs; odd ones use fanout 0 which counts as 1
    alloc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      alloc_fanout = (i % 2 == 1) ? 3'd0 : 3'd1;
      chk("drain_id", alloc_id, i);
      chk("drain_addr", alloc_addr, i * 128);
      tick(); @(negedge clk);
    end
    tick(); @(negedge clk);
    chk("empty_valid", alloc_valid, 0);
    chk("empty_free", free_cnt, 0);
    chk("empty_lowwm", low_wm, 1);
    alloc_ready = 1'b0;

    // Release 5 into the empty list: visible two cycles later
    release_valid = 1'b1; release_id = 4'd5;
    tick(); release_valid = 1'b0;
    @(negedge clk);
    chk("rel5_t1_valid", alloc_valid, 0);
    tick(); @(negedge clk);
    chk("rel5_t2_valid", alloc_valid, 1);
    chk("rel5_t2_id", alloc_id, 5);
    chk("rel5_t2_free", free_cnt, 1);

    // Multicast: id 3 allocated with fanout 3
    release_valid = 1'b1; release_id = 4'd3;
    tick(); release_valid = 1'b0;
    tick(); @(negedge clk);
    chk("pre_mc_free", free_cnt, 2);
    alloc_ready = 1'b1; alloc_fanout = 3'd1;
    tick(); alloc_fanout = 3'd3;
    tick(); alloc_ready = 1'b0;
    @(negedge clk);
    chk("mc_free0", free_cnt, 0);
    release_valid = 1'b1; release_id = 4'd3;
    tick(); tick(); tick();
    release_valid = 1'b0;
    @(negedge clk);
    chk("mc_after3_free", free_cnt, 0);
    chk("mc_after3_err", err_pulse, 0);
    tick(); @(negedge clk);
    chk("mc_push_free", free_cnt, 1);
    chk("mc_push_id", alloc_id, 3);
    release_valid = 1'b1; release_id = 4'd3;
    tick(); release_valid = 1'b0;
    @(negedge clk);
    chk("dbl_err", err_pulse, 1);
    chk("dbl_free", free_cnt, 1);
    tick(); @(negedge clk);
    chk("dbl_err_clear", err_pulse, 0);

    // Pop of 7 coinciding with the list push of a final release of 2
    release_valid = 1'b1; release_id = 4'd7;
    tick(); release_valid = 1'b0;
    tick();
    alloc_ready = 1'b1; alloc_fanout = 3'd1;
    tick(); alloc_ready = 1'b0;
    @(negedge clk);
    chk("pre_sim_head", alloc_id, 7);
    release_valid = 1'b1; release_id = 4'd2;
    tick(); release_valid = 1'b0; alloc_ready = 1'b1;
    tick(); alloc_ready = 1'b0;
    @(negedge clk);
    chk("sim_free", free_cnt, 1);
    chk("sim_head", alloc_id, 2);
    chk("sim_err", err_pulse, 0);

    // Release and pop in the same input cycle
    release_valid = 1'b1; release_id = 4'd4; alloc_ready = 1'b1;
    tick(); release_valid = 1'b0; alloc_ready = 1'b0;
    @(negedge clk);
    chk("same_free0", free_cnt, 0);
    tick(); @(negedge clk);
    chk("same_free1", free_cnt, 1);
    chk("same_id", alloc_id, 4);

    // Reset in the middle of traffic
    alloc_ready = 1'b1; release_valid = 1'b1; release_id = 4'd7;
    tick();
    rst_n = 1'b0; alloc_ready = 1'b0; release_valid = 1'b0;
    #1;
    chk("rst_valid", alloc_valid, 0);
    chk("rst_free", free_cnt, 0);
    chk("rst_init", init_done, 0);
    chk("rst_rrdy", release_ready, 0);
    chk("rst_lowwm", low_wm, 0);
    chk("rst_err", err_pulse, 0);
    chk("rst_id", alloc_id, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    release_valid = 1'b1; release_id = 4'd9;
    repeat (10) tick();
    release_valid = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    chk("rinit_done", init_done, 1);
    chk("rinit_err", err_pulse, 0);
    chk("rinit_free", free_cnt, 16);
    release_valid = 1'b1; release_id = 4'd7;
    tick(); release_valid = 1'b0;
    @(negedge clk);
    chk("stale_err", err_pulse, 1);
    chk("reissue_id0", alloc_id, 0);
    alloc_ready = 1'b1;
    tick(); @(negedge clk);
    chk("reissue_id1", alloc_id, 1);
    tick(); @(negedge clk);
    chk("reissue_id2", alloc_id, 2);
    alloc_ready = 1'b0;
    tick(); @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
